// File: rtl/rr_grant_sched.sv
// rr_grant_sched
//   Round-robin scheduler sharing one downstream slot among N requesters.
//   A rotating-priority search picks the winner. The grant is registered and
//   held until the requester releases it or the hold limit expires. Every
//   grant exit passes through at least one IDLE cycle before the next grant.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           gate for issuing new grants (ignored while a grant is active)
//   req[N]       level-sensitive request lines
//   gnt_valid    a grant is active
//   gnt_onehot   one-hot grant vector, zero when no grant is active
//   gnt_idx      granted requester index, zero when no grant is active
//   gnt_expired  one-cycle pulse when the hold limit revokes a grant
//   ptr          current highest-priority index
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; searches for a winner when en=1 and req!=0
// GRANT | grant held; exits on release or when the hold limit is reached
//
// Wrap arithmetic on ptr and on the rotating search assumes N == 2**IDX_W.
module rr_grant_sched #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_expired,
  output logic [IDX_W-1:0] ptr
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;

  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic [IDX_W-1:0]  cand;

  // First set request bit at or after ptr, wrapping around.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_valid   <= 1'b0;
      gnt_onehot  <= '0;
      gnt_idx     <= '0;
      gnt_expired <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      gnt_expired <= 1'b0;
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= win_idx;
            gnt_onehot <= N'(1) << win_idx;
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          // Release takes precedence over expiry on the same edge.
          if (!req[gnt_idx] || (hold_cnt == HOLD_LAST)) begin
            state       <= IDLE;
            gnt_valid   <= 1'b0;
            gnt_onehot  <= '0;
            gnt_idx     <= '0;
            ptr         <= gnt_idx + IDX_W'(1);
            hold_cnt    <= '0;
            gnt_expired <= req[gnt_idx];
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
